// File: rtl/midi_uart_rx.sv
// rtl/midi_uart_rx.sv - MIDI IN 8N1 byte receiver with framing-error and Active Sensing filter
module midi_uart_rx #(
  parameter int CLKS_PER_BIT        = 1600,
  parameter int FILTER_ACTIVE_SENSE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [7:0] midi_data,
  output logic       midi_valid,
  output logic       framing_error,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state, state_n;
  logic            sync1, rx_s;
  logic [CW-1:0]   cnt, cnt_n;
  logic [2:0]      bit_idx, bit_idx_n;
  logic [7:0]      shift_q, shift_n;
  logic [7:0]      data_n;
  logic            valid_n, ferr_n;
  logic            drop_byte;

  assign busy      = (state != S_IDLE);
  assign drop_byte = (FILTER_ACTIVE_SENSE != 0) && (shift_q == 8'hFE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1         <= 1'b1;
      rx_s          <= 1'b1;
      state         <= S_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      midi_data     <= '0;
      midi_valid    <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      sync1         <= rx_in;
      rx_s          <= sync1;
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_idx_n;
      shift_q       <= shift_n;
      midi_data     <= data_n;
      midi_valid    <= valid_n;
      framing_error <= ferr_n;
    end
  end

  // Counter is zeroed on every transition so each state times from its own entry.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shift_n   = shift_q;
    data_n    = midi_data;
    valid_n   = 1'b0;
    ferr_n    = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (!rx_s) state_n = S_START;
      end
      S_START: begin
        if (cnt == HALF_LAST) begin
          cnt_n     = '0;
          bit_idx_n = '0;
          state_n   = rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_s, shift_q[7:1]};
          if (bit_idx == 3'd7) state_n = S_STOP;
          else                 bit_idx_n = bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        // Leaving mid-stop-bit gives half a bit of slack for a following start edge.
        if (cnt == BIT_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            state_n = S_IDLE;
            if (!drop_byte) begin
              data_n  = shift_q;
              valid_n = 1'b1;
            end
          end else begin
            ferr_n  = 1'b1;
            state_n = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_n = '0;
        if (rx_s) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

endmodule

// File: doc/midi_uart_rx.md
Name: midi_uart_rx

Overview:
- Receives the raw 31250-baud MIDI serial line (8N1, LSB first) from the opto-isolated MIDI IN pin.
- Recovers bytes and presents them on the midi_data / midi_valid byte interface consumed by midi_player.
- Produces one single-cycle valid strobe per good byte.
- Flags framing errors and optionally suppresses Active Sensing (0xFE) bytes so they never reach the voices.

Parameters:
- CLKS_PER_BIT, 1600: system clocks per MIDI bit (50 MHz / 31250); must be even and ≥ 8.
- FILTER_ACTIVE_SENSE, 1: when 1, a correctly framed 0xFE byte is dropped with no midi_valid pulse.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- rx_in  input  1  raw MIDI serial line, idle high, asynchronous to clk.
- midi_data  output  8  last received byte; held stable until the next good byte.
- midi_valid  output  1  one-cycle strobe: midi_data holds a new byte.
- framing_error  output  1  one-cycle strobe: stop bit sampled low.
- busy  output  1  high while a frame is being received (any state except IDLE).

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, both synchronizer flops=1, shift register=0, bit counter=0, clock counter=0.
- Reset values of outputs: midi_data=0x00, midi_valid=0, framing_error=0, busy=0.
- Reset asserted mid-frame aborts the frame; no partial byte is ever output.
- Synchronizer: rx_in passes through 2 flops; rx_s is the second flop output. All decisions use rx_s only.
- Clock counter: cleared on every state entry, increments each cycle in the state. "Expires" means counter == limit-1, where limit is the state's duration.
- IDLE: rx_s==0 -> START.
- START (limit CLKS_PER_BIT/2): on expiry, sample rx_s.
  - 0 -> DATA with bit index=0.
  - 1 -> IDLE (glitch rejected, no strobe).
- DATA (limit CLKS_PER_BIT): on expiry, shift rx_s into the shift register LSB-first.
  - Bit index 7 -> STOP.
  - Otherwise increment the bit index and stay in DATA.
- STOP (limit CLKS_PER_BIT): on expiry, sample rx_s.
  - 1 and (byte≠0xFE or FILTER_ACTIVE_SENSE==0): load midi_data, pulse midi_valid; -> IDLE.
  - 1 and byte==0xFE and FILTER_ACTIVE_SENSE==1: no pulse, midi_data unchanged; -> IDLE.
  - 0: pulse framing_error, midi_data unchanged; -> BREAK.
- BREAK: wait for rx_s==1, then -> IDLE. A held-low line (break) yields exactly one framing_error and no bytes.
- Strobes: midi_valid and framing_error are registered, high exactly one cycle, never high together.
- Latency: first cycle rx_in is low -> midi_valid high = 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1 allowed at bench).
- Back-to-back frames: a start bit beginning directly after a stop bit is accepted; returning to IDLE half a bit early guarantees no loss.
- No running-status or message parsing here; that stays downstream.
- busy=1 in START, DATA, STOP and BREAK; 0 in IDLE.

Test Plan:
All scenarios use CLKS_PER_BIT=16 and FILTER_ACTIVE_SENSE=1 unless stated.
1. Single frame 0x90 on rx_in -> one midi_valid pulse with midi_data=0x90, at 2+8+144=154 cycles (±1) after the start edge; framing_error stays 0.
2. Back-to-back frames 0x90, 0x3C, 0x64 with no idle gap -> exactly three midi_valid pulses carrying 0x90, 0x3C, 0x64 in order, spaced 160 cycles apart.
3. rx_in low for 4 cycles then high -> no midi_valid, no framing_error; busy returns to 0 within 8 cycles. A following 0x45 frame is received correctly.
4. Frame 0x55 with stop bit driven 0, line held low for 100 cycles -> exactly one framing_error pulse, no midi_valid, midi_data keeps its prior value. After the line goes high, frame 0xAA -> midi_data=0xAA.
5. Frame 0xFE -> no midi_valid. Repeat with FILTER_ACTIVE_SENSE=0 -> midi_valid with midi_data=0xFE.
6. Assert rst during bit 3 of frame 0x90 -> outputs immediately 0, busy=0, no strobe for that frame. A clean frame 0x80 after release -> midi_data=0x80.
